// File: rtl/lcd_pkg.sv
// Shared LCD constants, sequencer state encoding and the window byte helper
// for the map-window scanner.
package lcd_pkg;

  localparam int SCR_W = 320;
  localparam int SCR_H = 480;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_PFILL,
    ST_PIXEL,
    ST_FINISH
  } state_t;

  // Window parameter bytes go out as first_hi, first_lo, last_hi, last_lo.
  function automatic logic [7:0] win_byte(input logic [15:0] first,
                                          input logic [15:0] last,
                                          input logic [1:0]  idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0:    b = first[15:8];
      2'd1:    b = first[7:0];
      2'd2:    b = last[15:8];
      default: b = last[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One 8080-style write: rs/db loaded on start, wr_n low WR_LOW cycles then
// high WR_HIGH cycles; done marks the final high cycle.
module lcd_bus_writer #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rs,
  input  logic [15:0] data,
  output logic        done,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic [15:0] lcd_db
);

  localparam int WR_MAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int CW     = (WR_MAX > 1) ? $clog2(WR_MAX) : 1;

  // Handshake: start is taken on any edge where it is high; the caller only
  // raises it while the writer is idle or in its done cycle, so writes chain
  // back-to-back with no gap.
  logic          active;
  logic          high_ph;
  logic [CW-1:0] cnt;

  assign done = active && high_ph && (cnt == CW'(WR_HIGH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      high_ph  <= 1'b0;
      cnt      <= '0;
      lcd_rs   <= 1'b1;
      lcd_wr_n <= 1'b1;
      lcd_db   <= 16'h0000;
    end else if (start) begin
      active   <= 1'b1;
      high_ph  <= 1'b0;
      cnt      <= '0;
      lcd_rs   <= rs;
      lcd_db   <= data;
      lcd_wr_n <= 1'b0;
    end else if (active) begin
      if (!high_ph) begin
        if (cnt == CW'(WR_LOW - 1)) begin
          high_ph  <= 1'b1;
          cnt      <= '0;
          lcd_wr_n <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (cnt == CW'(WR_HIGH - 1)) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lcd_map_scanner.sv
// Frame sequencer: programs the LCD window, sends RAMWR, then raster-scans
// the renderer and streams its pixels through the shared bus writer.
module lcd_map_scanner
  import lcd_pkg::*;
#(
  parameter int X_LEN    = SCR_W,
  parameter int Y_START  = SCR_H / 2,
  parameter int Y_LEN    = SCR_H - SCR_H / 2,
  parameter int WR_LOW   = 2,
  parameter int WR_HIGH  = 2,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_req,
  output logic        busy,
  output logic        frame_done,
  output logic [8:0]  pixel_x,
  output logic [8:0]  pixel_y,
  input  logic [15:0] disp_data,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [15:0] lcd_db,
  output state_t      dbg_state
);

  localparam logic [8:0]  X_LAST  = 9'(X_LEN - 1);
  localparam logic [8:0]  Y_FIRST = 9'(Y_START);
  localparam logic [8:0]  Y_LAST  = 9'(Y_START + Y_LEN - 1);
  localparam logic [15:0] XW_LO   = 16'd0;
  localparam logic [15:0] XW_HI   = 16'(X_LEN - 1);
  localparam logic [15:0] YW_LO   = 16'(Y_START);
  localparam logic [15:0] YW_HI   = 16'(Y_START + Y_LEN - 1);
  localparam int          PLW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [PLW-1:0] PL_LAST = PLW'(PIPE_LAT - 1);

  state_t         state;
  logic [1:0]     param_idx;
  logic           params_done;
  logic [PLW-1:0] fill_cnt;
  logic           last_issued;
  logic           wr_start;
  logic           wr_rs;
  logic [15:0]    wr_data;
  logic           wr_done;

  assign lcd_rd_n  = 1'b1;
  assign dbg_state = state;

  // Next write is chosen in the cycle the previous one finishes.
  always_comb begin
    wr_start = 1'b0;
    wr_rs    = 1'b1;
    wr_data  = 16'h0000;
    case (state)
      ST_START: begin
        wr_start = 1'b1;
        wr_rs    = 1'b0;
        wr_data  = {8'h00, CMD_CASET};
      end
      ST_CASET: if (wr_done) begin
        wr_start = 1'b1;
        if (params_done) begin
          wr_rs   = 1'b0;
          wr_data = {8'h00, CMD_PASET};
        end else begin
          wr_data = {8'h00, win_byte(XW_LO, XW_HI, param_idx)};
        end
      end
      ST_PASET: if (wr_done) begin
        wr_start = 1'b1;
        if (params_done) begin
          wr_rs   = 1'b0;
          wr_data = {8'h00, CMD_RAMWR};
        end else begin
          wr_data = {8'h00, win_byte(YW_LO, YW_HI, param_idx)};
        end
      end
      ST_PFILL: if (fill_cnt == PL_LAST) begin
        wr_start = 1'b1;
        wr_data  = disp_data;
      end
      ST_PIXEL: if (wr_done && !last_issued) begin
        wr_start = 1'b1;
        wr_data  = disp_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      lcd_cs_n    <= 1'b1;
      pixel_x     <= 9'd0;
      pixel_y     <= Y_FIRST;
      param_idx   <= 2'd0;
      params_done <= 1'b0;
      fill_cnt    <= '0;
      last_issued <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE, ST_FINISH: begin
          if (frame_req) begin
            state    <= ST_START;
            busy     <= 1'b1;
            lcd_cs_n <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_START: begin
          state       <= ST_CASET;
          param_idx   <= 2'd0;
          params_done <= 1'b0;
          last_issued <= 1'b0;
        end
        ST_CASET, ST_PASET: if (wr_done) begin
          if (params_done) begin
            state       <= (state == ST_CASET) ? ST_PASET : ST_RAMWR;
            params_done <= 1'b0;
            param_idx   <= 2'd0;
          end else begin
            param_idx <= param_idx + 2'd1;
            if (param_idx == 2'd3) params_done <= 1'b1;
          end
        end
        ST_RAMWR: if (wr_done) begin
          state    <= ST_PFILL;
          fill_cnt <= '0;
        end
        ST_PFILL: begin
          if (fill_cnt == PL_LAST) state <= ST_PIXEL;
          else fill_cnt <= fill_cnt + PLW'(1);
        end
        ST_PIXEL: if (wr_done && last_issued) begin
          state      <= ST_FINISH;
          busy       <= 1'b0;
          lcd_cs_n   <= 1'b1;
          frame_done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      // Each pixel write launches with the coordinate stepping forward, so the
      // renderer works on the next pixel while this one is on the bus.
      if (wr_start && (state == ST_PFILL || state == ST_PIXEL)) begin
        if (pixel_x == X_LAST) begin
          pixel_x <= 9'd0;
          if (pixel_y == Y_LAST) begin
            pixel_y     <= Y_FIRST;
            last_issued <= 1'b1;
          end else begin
            pixel_y <= pixel_y + 9'd1;
          end
        end else begin
          pixel_x <= pixel_x + 9'd1;
        end
      end
    end
  end

  lcd_bus_writer #(
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_writer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .done     (wr_done),
    .lcd_rs   (lcd_rs),
    .lcd_wr_n (lcd_wr_n),
    .lcd_db   (lcd_db)
  );

endmodule

// File: tb/tb_lcd_map_scanner.sv
// Bench for lcd_map_scanner on a reduced 260x4 window: frame-level model of
// the bus writes and control outputs, checked every cycle.
module tb_lcd_map_scanner;
  import lcd_pkg::*;

  localparam int X_LEN     = 260;
  localparam int Y_START   = 240;
  localparam int Y_LEN     = 4;
  localparam int WR_LOW    = 2;
  localparam int WR_HIGH   = 2;
  localparam int PIPE_LAT  = 1;
  localparam int N_PIX     = X_LEN * Y_LEN;
  localparam int WR_PER    = WR_LOW + WR_HIGH;
  localparam int FRAME_LEN = 1 + 11 * WR_PER + PIPE_LAT + N_PIX * WR_PER + 1;

  // Hand-derived first 12 writes {rs,db} for this window.
  localparam logic [16:0] LIT [12] = '{
    17'h0002A, 17'h10000, 17'h10000, 17'h10001, 17'h10003,
    17'h0002B, 17'h10000, 17'h100F0, 17'h10000, 17'h100F3,
    17'h0002C, 17'h1F000
  };

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_req;
  logic        busy, frame_done;
  logic [8:0]  pixel_x, pixel_y;
  logic [15:0] disp_data = 16'h0000;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
  logic [15:0] lcd_db;
  state_t      dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Renderer stand-in, one register of latency.
  always @(posedge clk) disp_data <= {pixel_y[7:0], pixel_x[7:0]};

  lcd_map_scanner #(
    .X_LEN(X_LEN), .Y_START(Y_START), .Y_LEN(Y_LEN),
    .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .busy(busy),
    .frame_done(frame_done), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .disp_data(disp_data), .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs),
    .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n), .lcd_db(lcd_db),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q[$];
  logic        frame_active = 1'b0;
  int          req_cyc = 0;
  int          w_cnt = 0;
  int          pix_seen = 0;
  logic [16:0] frame_w [12];
  logic [15:0] last_data = 16'h0;
  int          frames_done = 0;
  logic [16:0] snap_w [12];
  int          snap_count = 0;
  logic [15:0] snap_last = 16'h0;
  int          dut_done_off = 0;
  logic        prev_wr_n = 1'b1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at t=%0t", name, $time);
  endfunction

  // Expected writes of one frame, straight from the window and renderer rules.
  function automatic void push_frame();
    int x_end, y_end;
    x_end = X_LEN - 1;
    y_end = Y_START + Y_LEN - 1;
    exp_q.push_back({1'b0, 8'h00, CMD_CASET});
    exp_q.push_back(17'h10000 | 17'((0 >> 8) & 255));
    exp_q.push_back(17'h10000 | 17'(0 & 255));
    exp_q.push_back(17'h10000 | 17'((x_end >> 8) & 255));
    exp_q.push_back(17'h10000 | 17'(x_end & 255));
    exp_q.push_back({1'b0, 8'h00, CMD_PASET});
    exp_q.push_back(17'h10000 | 17'((Y_START >> 8) & 255));
    exp_q.push_back(17'h10000 | 17'(Y_START & 255));
    exp_q.push_back(17'h10000 | 17'((y_end >> 8) & 255));
    exp_q.push_back(17'h10000 | 17'(y_end & 255));
    exp_q.push_back({1'b0, 8'h00, CMD_RAMWR});
    for (int y = Y_START; y <= y_end; y++)
      for (int x = 0; x < X_LEN; x++)
        exp_q.push_back(17'h10000 | 17'(((y & 255) << 8) | (x & 255)));
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [16:0] ev, e;
    int          off;
    logic        exp_busy, exp_done;
    if (!rst_n) begin
      check("reset_ctrl", 32'({busy, frame_done, lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs}),
            32'(6'b001111));
      check("reset_db", 32'(lcd_db), 32'h0);
      check("reset_pixel", 32'({pixel_x, pixel_y}), 32'({9'd0, 9'(Y_START)}));
      check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
      frame_active = 1'b0;
      exp_q.delete();
      prev_wr_n = 1'b1;
    end else begin
      if (!prev_wr_n && lcd_wr_n) begin
        ev = {lcd_rs, lcd_db};
        check("cs_at_write", 32'(lcd_cs_n), 32'h0);
        if (exp_q.size() == 0) begin
          check("bus_extra_write", 32'(ev), 32'h1FFFF);
        end else begin
          e = exp_q.pop_front();
          check("bus_write", 32'(ev), 32'(e));
        end
        if (w_cnt < 12) frame_w[w_cnt] = ev;
        if (w_cnt >= 11) begin
          pix_seen++;
          last_data = lcd_db;
        end
        w_cnt++;
      end
      prev_wr_n = lcd_wr_n;

      off      = cyc - req_cyc;
      exp_busy = frame_active && off >= 1 && off <= FRAME_LEN - 1;
      exp_done = frame_active && off == FRAME_LEN;
      check("ctrl_busy_done_cs_rd", 32'({busy, frame_done, lcd_cs_n, lcd_rd_n}),
            32'({exp_busy, exp_done, ~exp_busy, 1'b1}));
      if (!frame_active) check("idle_wr_n", 32'(lcd_wr_n), 32'h1);
      if (frame_done) dut_done_off = off;
      if (exp_done) begin
        check("all_writes_seen", 32'(exp_q.size()), 32'h0);
        frame_active = 1'b0;
        snap_w     = frame_w;
        snap_count = pix_seen;
        snap_last  = last_data;
        frames_done++;
      end
      if (frame_req && !exp_busy) begin
        frame_active = 1'b1;
        req_cyc      = cyc;
        w_cnt        = 0;
        pix_seen     = 0;
        last_data    = 16'h0;
        push_frame();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_req();
    @(posedge clk); #1 frame_req = 1'b1;
    @(posedge clk); #1 frame_req = 1'b0;
  endtask

  task automatic wait_pix(input int n);
    int guard;
    guard = 0;
    while (pix_seen < n && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (pix_seen < n) timeout("wait_pix");
  endtask

  task automatic wait_frames(input int n);
    int guard;
    guard = 0;
    while (frames_done < n && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (frames_done < n) timeout("wait_frame_done");
  endtask

  task automatic check_snap(input string tag);
    for (int i = 0; i < 12; i++)
      check({tag, "_first12"}, 32'(snap_w[i]), 32'(LIT[i]));
    check({tag, "_pixel_count"}, 32'(snap_count), 32'd1040);
    check({tag, "_last_pixel"}, 32'(snap_last), 32'h0000F303);
    check({tag, "_done_offset"}, 32'(dut_done_off), 32'd4207);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a_req, guard;
    frame_req = 1'b0;
    rst_n     = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);

    // Frame A, with a stray request mid-frame.
    pulse_req();
    a_req = req_cyc;
    check("model_len", 32'(exp_q.size()), 32'd1051);
    check("model_caset_end_lo", 32'(exp_q[4]), 32'h10003);
    check("model_paset_end_lo", 32'(exp_q[9]), 32'h100F3);
    check("model_pix1", 32'(exp_q[11]), 32'h1F000);
    check("model_pix261", 32'(exp_q[271]), 32'h1F100);
    check("model_pix_last", 32'(exp_q[1050]), 32'h1F303);
    wait_pix(100);
    pulse_req();

    // Request placed exactly in the frame_done cycle of frame A.
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (cyc != a_req + FRAME_LEN && guard < 20000);
    if (cyc != a_req + FRAME_LEN) timeout("wait_done_cycle");
    frame_req = 1'b1;
    @(posedge clk); #1 frame_req = 1'b0;
    check("frames_after_a", 32'(frames_done), 32'd1);
    check_snap("frame_a");

    // Frame B is abandoned by reset while wr_n is low.
    wait_pix(500);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (lcd_wr_n && guard < 16);
    check("wr_n_low_before_reset", 32'(lcd_wr_n), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("reset_immediate", 32'({lcd_cs_n, lcd_wr_n, busy}), 32'(3'b110));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("no_done_after_abort", 32'(frames_done), 32'd1);

    // Frame C restarts cleanly from window setup.
    pulse_req();
    wait_frames(2);
    check_snap("frame_c");

    repeat (10) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_map_scanner.md
Name: lcd_map_scanner

Overview:
- Frame-scan sequencer for the lower-half map window (x 0–319, y 240–479) of the 320×480 LCD.
- On request it programs the LCD column/page window and issues the RAM-write command.
- It then raster-scans pixel coordinates into the map renderer and streams the returned 16-bit RGB565 pixels to the LCD over an 8080-style parallel bus.
- Placement: pixel_x/pixel_y feed the renderer; the renderer's disp_data comes back into this block.

Parameters:
- X_LEN, 320, pixels per line.
- Y_START, 240, first screen row of the window.
- Y_LEN, 240, number of rows.
- WR_LOW, 2, clk cycles lcd_wr_n is held low per bus write (≥1).
- WR_HIGH, 2, clk cycles lcd_wr_n is held high per bus write (≥1).
- PIPE_LAT, 1, cycles from pixel_x/pixel_y change to matching disp_data. Constraint: WR_LOW+WR_HIGH ≥ PIPE_LAT.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain; asynchronous, active-low.
- frame_req  in  1  single-cycle request to redraw the window.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse when the frame completes.
- pixel_x  out  9  screen x of the pixel being requested from the renderer.
- pixel_y  out  9  screen y of the pixel being requested.
- disp_data  in  16  renderer pixel, valid PIPE_LAT cycles after the coordinate.
- lcd_cs_n  out  1  chip select, active-low.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_wr_n  out  1  write strobe; LCD latches on the rising edge.
- lcd_rd_n  out  1  tied high (no reads).
- lcd_db  out  16  parallel data bus.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-frame) drives:
  - state IDLE, busy=0, frame_done=0;
  - lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=1, lcd_db=0;
  - pixel_x=0, pixel_y=Y_START.
- Reset mid-frame abandons the frame with no frame_done. The next request restarts from window setup.
- frame_req is sampled only in IDLE; it is ignored while busy=1. A request in the frame_done cycle is accepted, because that cycle is already IDLE.
- Bus write primitive:
  - lcd_db and lcd_rs are set in the first cycle.
  - lcd_wr_n is low for WR_LOW cycles, then high for WR_HIGH cycles.
  - lcd_db and lcd_rs are stable over the whole low phase and the rising edge.
- Command bytes sit on lcd_db[7:0] with lcd_db[15:8]=0.
- State sequence (a "param" is a data write with rs=1):
  - IDLE →(frame_req) START: lcd_cs_n=0, busy=1.
  - CASET: cmd 0x2A, params 0x00,0x00,0x01,0x3F.
  - PASET: cmd 0x2B, params 0x00,0xF0,0x01,0xDF.
  - RAMWR: cmd 0x2C.
  - PFILL: present pixel (0,Y_START) and wait PIPE_LAT cycles.
  - PIXEL: stream 76800 data writes.
  - FINISH: lcd_cs_n=1, busy=0, frame_done=1 for one cycle → IDLE.
- Window parameter bytes are derived from X_LEN/Y_START/Y_LEN (end = start+len−1), not hard literals.
- PIXEL pipelining:
  - In the first cycle of each pixel write, lcd_db latches disp_data.
  - In that same cycle the coordinate advances to the next pixel.
  - The next pixel's data is therefore ready by the next write (latency hidden); pixel period = WR_LOW+WR_HIGH cycles.
- Scan order: x 0→X_LEN−1; wrap x→0 with y+1; y runs Y_START→Y_START+Y_LEN−1.
- After the last pixel (319,479), the coordinate returns to (0,Y_START) and is held there.
- Counters:
  - x and y are 9-bit. Y_START+Y_LEN−1 must be ≤ 511.
  - A parameter-byte index counts 0–3.
  - A wr-phase counter is sized for max(WR_LOW,WR_HIGH).
- Frame length in clk cycles: 1 (START) + 11 writes·(WR_LOW+WR_HIGH) + PIPE_LAT + 76800·(WR_LOW+WR_HIGH) + 1 (FINISH).

Decomposition:
- Shared package (lcd_pkg):
  - LCD command constants: CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C.
  - State encoding.
  - Screen constants SCR_W=320, SCR_H=480.
- One sub-module, lcd_bus_writer:
  - Handles start/rs/data in, done pulse out, and the WR_LOW/WR_HIGH strobe timing.
  - Reused by every state of the sequencer.

Test Plan:
- Reset values: hold rst=0 → all outputs at their reset values. Release, leave idle for 100 cycles → no lcd_wr_n edges.
- Command sequence: frame_req pulse → the first 12 rising edges of lcd_wr_n carry, in order, (rs,db):
  - (0,0x2A),(1,0x00),(1,0x00),(1,0x01),(1,0x3F);
  - (0,0x2B),(1,0x00),(1,0xF0),(1,0x01),(1,0xDF);
  - (0,0x2C).
  - lcd_cs_n stays low throughout.
- Pixel mapping: renderer model disp_data = {pixel_y[7:0],pixel_x[7:0]} registered with PIPE_LAT=1 →
  - data write 1 = 16'hF000 (0,240);
  - write 321 = 16'hF100 (0,241);
  - last write = 16'hDF3F (319,479);
  - exactly 76800 data writes.
- Timing: with WR_LOW=2, WR_HIGH=2 → frame_done occurs exactly 1+44+1+307200+1 cycles after the frame_req cycle; busy is high throughout; frame_done lasts one cycle.
- Request filtering: frame_req at pixel 1000 → ignored, count still 76800. frame_req in the frame_done cycle → new frame starts with 0x2A.
- Reset mid-frame: rst=0 at pixel 5000 → lcd_cs_n=1, lcd_wr_n=1 immediately, no frame_done. After release, frame_req → full sequence from 0x2A with 76800 pixels.
